// File: rtl/barrel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrel_pkg : shared constants and types for barrel_shifter_pipe       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package barrel_pkg;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Width-independent part of the per-stage payload; data, amt and tag
  // widths depend on the instance parameters and travel beside it.
  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
  } stage_ctl_t;

  // Vacated-bit value for non-rotate shifts: only arithmetic right copies
  // the sign bit, everything else (including mode 11) fills with zero.
  function automatic logic shift_fill(input stage_ctl_t ctl, input logic msb);
    if (ctl.mode == MODE_LSL || ctl.dir == DIR_LEFT) begin
      return 1'b0;
    end
    return (ctl.mode == MODE_ASR && ctl.dir == DIR_RIGHT) ? msb : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrel_shift_stage : fixed-distance shift plus one elastic register  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int TAG_W = 4,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AMT_W-1:0] up_amt,
  input  stage_ctl_t       up_ctl,
  input  logic [TAG_W-1:0] up_tag,
  output logic             advance,
  input  logic             dn_advance,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic [AMT_W-1:0] dn_amt,
  output stage_ctl_t       dn_ctl,
  output logic [TAG_W-1:0] dn_tag
);

  localparam int AMT_BIT = $clog2(SHIFT);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  stage_ctl_t       r_ctl;
  logic [TAG_W-1:0] r_tag;

  logic [WIDTH-1:0] w_shifted;
  logic             w_fill;

  // Earlier arithmetic-right stages have already sign-filled, so the
  // current MSB is still the original MSB.
  assign w_fill = shift_fill(up_ctl, up_data[WIDTH-1]);

  always_comb begin
    w_shifted = up_data;
    if (up_amt[AMT_BIT]) begin
      if (up_ctl.dir == DIR_LEFT) begin
        if (up_ctl.mode == MODE_ROT) begin
          w_shifted = {up_data[WIDTH-SHIFT-1:0], up_data[WIDTH-1:WIDTH-SHIFT]};
        end else begin
          w_shifted = {up_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        end
      end else begin
        if (up_ctl.mode == MODE_ROT) begin
          w_shifted = {up_data[SHIFT-1:0], up_data[WIDTH-1:SHIFT]};
        end else begin
          w_shifted = {{SHIFT{w_fill}}, up_data[WIDTH-1:SHIFT]};
        end
      end
    end
  end

  // An empty stage can always take a word, so bubbles collapse.
  assign advance = ~r_valid | dn_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_ctl   <= '0;
      r_tag   <= '0;
    end else if (advance) begin
      r_valid <= up_valid;
      r_data  <= w_shifted;
      r_amt   <= up_amt;
      r_ctl   <= up_ctl;
      r_tag   <= up_tag;
    end
  end

  assign dn_valid = r_valid;
  assign dn_data  = r_data;
  assign dn_amt   = r_amt;
  assign dn_ctl   = r_ctl;
  assign dn_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrel_shifter_pipe : log2-staged rotate/shift pipeline, valid/ready |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int TAG_W  = 4,
  localparam int NSTAGE = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [NSTAGE-1:0] in_amt,
  input  logic              in_dir,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  // Index k is the input of stage k; index NSTAGE is the output port side.
  logic              w_valid [NSTAGE+1];
  logic              w_adv   [NSTAGE+1];
  logic [WIDTH-1:0]  w_data  [NSTAGE+1];
  logic [NSTAGE-1:0] w_amt   [NSTAGE+1];
  stage_ctl_t        w_ctl   [NSTAGE+1];
  logic [TAG_W-1:0]  w_tag   [NSTAGE+1];

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_ctl[0]   = '{dir: in_dir, mode: in_mode};
  assign w_tag[0]   = in_tag;

  assign w_adv[NSTAGE] = ~w_valid[NSTAGE] | out_ready;
  assign in_ready      = w_adv[0];

  generate
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      barrel_shift_stage #(
        .WIDTH (WIDTH),
        .AMT_W (NSTAGE),
        .TAG_W (TAG_W),
        .SHIFT (1 << k)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (w_valid[k]),
        .up_data    (w_data[k]),
        .up_amt     (w_amt[k]),
        .up_ctl     (w_ctl[k]),
        .up_tag     (w_tag[k]),
        .advance    (w_adv[k]),
        .dn_advance (w_adv[k+1]),
        .dn_valid   (w_valid[k+1]),
        .dn_data    (w_data[k+1]),
        .dn_amt     (w_amt[k+1]),
        .dn_ctl     (w_ctl[k+1]),
        .dn_tag     (w_tag[k+1])
      );
    end
  endgenerate

  assign out_valid = w_valid[NSTAGE];
  assign out_data  = w_data[NSTAGE];
  assign out_tag   = w_tag[NSTAGE];

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_barrel_shifter_pipe : scoreboard bench for barrel_shifter_pipe    |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_barrel_shifter_pipe;

  localparam int NSTAGE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amt = '0;
  logic       in_dir = 1'b0;
  logic [1:0] in_mode = '0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_tag;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_data4 = '0;
  logic [1:0] in_amt4 = '0;
  logic       in_dir4 = 1'b0;
  logic [1:0] in_mode4 = '0;
  logic [3:0] in_tag4 = '0;
  logic       out_valid4;
  logic [3:0] out_data4;
  logic [3:0] out_tag4;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_dir(in_dir), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  barrel_shifter_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_amt(in_amt4),
    .in_dir(in_dir4), .in_mode(in_mode4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(1'b1), .out_data(out_data4), .out_tag(out_tag4)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] tag;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   hold_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                           input logic dir, input logic [1:0] mode);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < amt; i++) begin
      if (dir) begin
        case (mode)
          2'b00:   r = {r[0], r[7:1]};
          2'b10:   r = {r[7], r[7:1]};
          default: r = {1'b0, r[7:1]};
        endcase
      end else if (mode == 2'b00) begin
        r = {r[6:0], r[7]};
      end else begin
        r = {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("out_data", 32'(out_data), 32'(e.data));
          check_eq("out_tag", 32'(out_tag), 32'(e.tag));
          if (lat_chk) check_eq("latency", cyc - e.acc, NSTAGE);
        end
      end else if (hold_chk && exp_q.size() > 0) begin
        check_eq("hold_data", 32'(out_data), 32'(exp_q[0].data));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] amt, input logic dir,
                      input logic [1:0] mode, input logic [3:0] tag, output int stalled);
    int   waits;
    exp_t e;
    stalled = 0;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_amt = amt;
    in_dir = dir;
    in_mode = mode;
    in_tag = tag;
    #1;
    while (!in_ready) begin
      stalled = 1;
      waits++;
      if (waits > 100) begin
        check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.data = ref_shift(d, int'(amt), dir, mode);
    e.tag = tag;
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2;
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send4(input string tag, input logic [3:0] d, input logic [1:0] amt,
                       input logic dir, input logic [1:0] mode, input logic [3:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    in_valid4 = 1'b1;
    in_data4 = d;
    in_amt4 = amt;
    in_dir4 = dir;
    in_mode4 = mode;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid4), 1);
    check_eq(tag, 32'(out_data4), 32'(exp));
  endtask

  initial begin
    int st;
    int stall_cnt;
    logic [1:0] m;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_tag", 32'(out_tag), 0);
    check_eq("rst_out_valid4", 32'(out_valid4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with exact latency
    lat_chk = 1'b1;
    send(8'b1011_0001, 3'd3, 1'b1, 2'b00, 4'd1, st);
    send(8'b1011_0001, 3'd3, 1'b1, 2'b01, 4'd2, st);
    send(8'b1011_0001, 3'd3, 1'b1, 2'b10, 4'd3, st);
    send(8'b1011_0001, 3'd2, 1'b0, 2'b01, 4'd4, st);
    send(8'b1011_0001, 3'd2, 1'b0, 2'b10, 4'd5, st);
    send(8'b1011_0001, 3'd3, 1'b1, 2'b11, 4'd6, st);
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      send(8'b1101_0010, 3'd0, 1'(i & 1), m, 4'(7 + i), st);
    end
    drain();

    // Back-to-back stream, tags 0..9
    stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'(i), st);
      stall_cnt += st;
    end
    check_eq("stream_in_ready", stall_cnt, 0);
    drain();

    // Backpressure: fill, confirm in_ready drops and output holds, then drain
    lat_chk = 1'b0;
    hold_chk = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom_range(0, 255)), 3'($urandom_range(1, 7)), 1'b1, 2'b10, 4'(10 + i), st);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h5A;
    #1;
    check_eq("in_ready_full", 32'(in_ready), 0);
    check_eq("out_valid_full", 32'(out_valid), 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("in_ready_still_full", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(8'h5A, 3'd5, 1'b0, 2'b00, 4'd13, st);
    send(8'hC3, 3'd7, 1'b1, 2'b10, 4'd14, st);
    drain();

    // Random stream with random consumer stalls
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 4'(i), st);
        end
      end
      begin
        repeat (120) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    hold_chk = 1'b0;

    // Asynchronous reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hF0, 3'd1, 1'b1, 2'b10, 4'd5, st);
    send(8'h0F, 3'd2, 1'b0, 2'b01, 4'd6, st);
    @(posedge clk);
    #2;
    check_eq("pre_reset_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 0);
    check_eq("async_rst_data", 32'(out_data), 0);
    check_eq("async_rst_tag", 32'(out_tag), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check_eq("no_stale_word", 32'(out_valid), 0);
    lat_chk = 1'b1;
    send(8'b1011_0001, 3'd3, 1'b1, 2'b00, 4'd9, st);
    drain();
    lat_chk = 1'b0;

    // WIDTH=4 instance
    send4("w4_rot_right", 4'b0110, 2'd1, 1'b1, 2'b00, 4'b0011);
    send4("w4_rot_left", 4'b0110, 2'd1, 1'b0, 2'b00, 4'b1100);
    send4("w4_amt0", 4'b0110, 2'd0, 1'b1, 2'b00, 4'b0110);
    send4("w4_asr", 4'b1001, 2'd3, 1'b1, 2'b10, 4'b1111);

    repeat (4) @(negedge clk);
    check_eq("leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined successor to the 4-bit mux barrel shifter. Rotates or shifts a WIDTH-bit word left or right by 0..WIDTH-1 positions, in logical, arithmetic or rotate mode. One log2 stage per pipeline register, with valid/ready handshakes on both sides. Sits between a producer and a consumer on streaming datapaths, one word per cycle at full throughput.

Parameters:
WIDTH, 8, data width; power of two, at least 4.
TAG_W, 4, width of a sideband tag carried unchanged alongside the data.
NSTAGE, $clog2(WIDTH), number of pipeline stages; derived, not overridden.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block accepts the input word this cycle
in_data  input  WIDTH  word to shift
in_amt  input  NSTAGE  shift amount, 0..WIDTH-1
in_dir  input  1  1 = right, 0 = left (same polarity as the 4-bit shifter)
in_mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 logical
in_tag  input  TAG_W  sideband, passed through
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of out_data

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n=0, all stage valid bits clear and all stage data, amt, dir, mode and tag registers clear to 0. out_valid=0, out_data=0, out_tag=0. Asserting reset mid-operation discards in-flight words with no output.
- Stage k (k=0..NSTAGE-1) shifts by 2^k when amt bit k is 1; otherwise it passes the word through. Each stage's result is registered with its valid bit, dir, mode, tag and amt.
- Accepted word: a word is accepted when in_valid and in_ready are both 1.
- Latency: the result appears on out_valid exactly NSTAGE cycles after acceptance if nothing stalls. Throughput is 1 word per cycle.
- Flow control: stage k advances when its own valid is 0 or stage k+1 advances. The last stage advances when out_valid is 0 or out_ready is 1.
- in_ready equals stage 0 advance. It is a combinational path from out_ready; bubbles collapse.
- Stalls: while stalled, a stage holds all its registers. out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Rotate mode: bits leaving one end enter the other.
- Logical mode: vacated bits are 0.
- Arithmetic mode, right: vacated bits take the original MSB.
- Arithmetic mode, left: identical to logical left.
- Mode 11: behaves as logical mode.
- in_amt=0: out_data equals in_data in every mode.
- Simultaneous events: accept and emit in the same cycle is legal, and the pipeline keeps its occupancy.
- Capacity: at most NSTAGE words are in flight. When all stages are full and out_ready=0, in_ready=0.
- Input stability: in_* values need not be held after acceptance. Values on in_* while in_valid=0 are ignored.

Decomposition:
- Package barrel_pkg holds:
  - mode constants MODE_ROT=2'b00, MODE_LSL=2'b01, MODE_ASR=2'b10;
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1;
  - a stage-payload struct typedef {data, amt, dir, mode, tag}.
- Sub-module barrel_shift_stage, parametrised by WIDTH and the shift distance.
  - Combinational fixed-distance shift plus a register with the valid/advance logic.
  - The top instantiates NSTAGE copies in a generate loop.

Test Plan:
- WIDTH=8, in_data=8'b10110001, amt=3, dir=1, mode=00 -> out_data=8'b00110110, out_valid exactly 3 cycles after acceptance.
- Same data, amt=3, dir=1: mode=01 -> 8'b00010110; mode=10 -> 8'b11110110. Same data, amt=2, dir=0, mode=01 -> 8'b11000100; mode=10 gives the same result.
- WIDTH=4, mode=00, in_data=4'b0110, amt=1: dir=1 -> 4'b0011; dir=0 -> 4'b1100. amt=0 -> 4'b0110, unchanged.
- Back-to-back stream of 10 words with tags 0..9 and out_ready=1 -> in_ready constantly 1, results in order, tags match, no gaps.
- Backpressure, stream with out_ready=0:
  - in_ready drops to 0 after 3 acceptances (WIDTH=8), and out_data holds stable.
  - After out_ready rises, all words drain in order with no loss or duplication.
- Reset mid-stream: rst_n=0 with 2 words in flight -> out_valid=0 and out_data=0 immediately, without a clock edge. After release, no stale words emerge and the next word has normal latency.
